hue_stage2: RTL
===============

# hue_stage2

Final stage of the RGB-to-hue path in the color-detect pipeline. It consumes the signed fixed-point quotient from `hue_stage1`, which is the hue numerator divided by chroma, and re-aligns it with the per-pixel sideband tag (max-channel sector, gray flag) issued when the divide was launched. The tag is buffered in a small FIFO across the divider latency. The block scales the quotient by 60, adds the sector offset and wraps the result into 0..359 degrees for the threshold/detect logic.

## Interface
Parameters:
- `DIVIDE_LATENCY`, default 16: latency of `hue_stage1`; sets minimum useful tag depth.
- `TAG_DEPTH`, default 32: tag FIFO entries; power of 2, at least `DIVIDE_LATENCY`+2.
- `QUO_W`, default 16: quotient width; signed Q8.8.
- `HUE_W`, default 9: output hue width.

Ports:
- `i_clk`, in, 1: sole clock.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_tag_valid`, in, 1: pulses in the same cycle the divide is launched (`hue_stage1` `i_valid`).
- `i_sector`, in, 2: 0 = R max, 1 = G max, 2 = B max, 3 = reserved.
- `i_gray`, in, 1: chroma is zero; the quotient is meaningless and hue is forced to 0.
- `i_quo`, in, `QUO_W`: `hue_stage1` `o_data`, signed Q8.8.
- `i_quo_valid`, in, 1: `hue_stage1` `o_valid`.
- `o_hue`, out, `HUE_W`: hue in degrees, 0..359.
- `o_valid`, out, 1: `o_hue` is valid this cycle.
- `o_tag_full`, out, 1: tag FIFO is full (status only).
- `o_err`, out, 1: sticky error; cleared only by `i_rst`.

## Operation
Tag FIFO:
- `i_tag_valid` pushes {sector, gray}.
- `i_quo_valid` pops the head; the head is show-ahead, readable in the pop cycle.
- Overflow: a push while full with no pop in the same cycle drops the tag and sets `o_err`.
- Full with a simultaneous push and pop: both succeed; count is unchanged.
- Underflow: `i_quo_valid` while the FIFO is empty sets `o_err`. No `o_valid` results for that quotient. A push in the same cycle does not rescue it; the pushed tag is stored.
- Pointers wrap modulo `TAG_DEPTH`.

Stage A, registered on `i_quo_valid` with a successful pop:
- Saturate q to [-256, +256], i.e. ±1.0.
- Compute signed product p = q*60, 17 bits including sign.
- Register the tag alongside p.

Stage B, registered:
- d = p >>> 8, an arithmetic shift. With `HUE_STAGE2_ROUND_EN`, add 128 before the shift.
- h = offset + d, where offset is 0, 120 or 240 by sector.
- h < 0 gives h + 360; h ≥ 360 gives h − 360.
- Gray tag forces h = 0.
- Sector 3 forces h = 0 and sets `o_err`; `o_valid` is still asserted.

There is no backpressure; one result is accepted per cycle.

Reset mid-operation:
- FIFO pointers and count clear, and both stage valids clear.
- Divider results still in flight then underflow and set `o_err`. `hue_stage1` shares `i_rst` so this does not happen in normal use.

## Timing
- Reset values: `o_hue` = 0, `o_valid` = 0, `o_tag_full` = 0, `o_err` = 0, FIFO empty.
- Latency: `i_quo_valid` at cycle N gives `o_valid` at N+2. Throughput is 1 per cycle.
- End-to-end from tag launch to hue: `DIVIDE_LATENCY` + 2 cycles.
- `o_tag_full` is registered and reflects the count after the current cycle's push/pop.
- `o_err` asserts the cycle after the offending event and holds.
- `o_hue` holds its last value while `o_valid` = 0.

## Configuration
- `HUE_STAGE2_ROUND_EN` defined: round half up, adding 128 before the shift.
- Undefined: truncate, i.e. floor via the arithmetic shift.
- All other behaviour is identical with or without the macro.

## Structure
`hue_pkg` holds:
- A sector enum (R/G/B/RSVD).
- Tag struct {sector, gray}.
- Constants `HUE_OFF_R` = 0, `HUE_OFF_G` = 120, `HUE_OFF_B` = 240, `HUE_MAX` = 360, `HUE_SCALE` = 60.

One sub-module, `hue_tag_fifo`: parameterized show-ahead FIFO with push/pop, full/empty and overflow/underflow strobes. `hue_stage2` instantiates it and implements the two arithmetic stages.

## Test plan
- Basic positive: push sector 0, gray 0; 16 cycles later `i_quo` = 0x0080 (+0.5) → `o_hue` = 30, `o_valid` two cycles after the quo.
- Negative wrap and saturation:
  - Sector 0, q = 0xFF80 (−0.5) → 330.
  - Sector 1, q = 0xFF00 (−1.0) → 60.
  - Sector 2, q = 0x0100 → 300.
  - Sector 0, q = 0x0200 → 60 (saturated to +1.0).
- Gray and reserved:
  - Gray = 1, q = 0x7FFF → `o_hue` = 0, `o_err` stays 0.
  - Sector 3 → `o_hue` = 0, `o_valid` = 1, `o_err` = 1.
- Rounding: sector 0, q = 0x0003 → 1 with `HUE_STAGE2_ROUND_EN`, 0 without. q = 0xFFFD → 359 in both builds.
- Back-to-back: 20 consecutive tags and 20 consecutive quotients with mixed sectors → 20 in-order `o_valid` results, all matching a reference model.
- Boundaries:
  - 32 pushes with no pops → `o_tag_full` = 1, `o_err` = 0.
  - Next push with a simultaneous pop → no error.
  - Next push alone → `o_err` = 1.
  - After reset, `i_quo_valid` on the empty FIFO → `o_err` = 1, no `o_valid`.

Source files
------------

// File: rtl/hue_pkg.sv
// Shared types and constants for the RGB-to-hue back end.
package hue_pkg;

    // Which channel held the maximum when the divide was launched
    typedef enum logic [1:0] {
        SEC_R    = 2'd0,
        SEC_G    = 2'd1,
        SEC_B    = 2'd2,
        SEC_RSVD = 2'd3
    } sector_e;

    // Sideband carried across the divider latency
    typedef struct packed {
        sector_e sector;
        logic    gray;
    } hue_tag_t;

    localparam int HUE_OFF_R = 0;
    localparam int HUE_OFF_G = 120;
    localparam int HUE_OFF_B = 240;
    localparam int HUE_MAX   = 360;
    localparam int HUE_SCALE = 60;
    localparam int TAG_W     = $bits(hue_tag_t);

endpackage

// File: rtl/hue_tag_fifo.sv
// Show-ahead tag FIFO: head is readable combinationally in the pop cycle.
// A push into a full FIFO succeeds only if a pop happens in the same cycle.
module hue_tag_fifo
    import hue_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int W     = TAG_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_ovf,
    output logic         o_udf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full_r;
    logic             push_ok;
    logic             pop_ok;

    assign o_empty = (count == '0);
    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~full_r | pop_ok);
    assign o_ovf   = i_push & full_r & ~pop_ok;
    assign o_udf   = i_pop & o_empty;
    assign o_full  = full_r;
    assign o_head  = mem[rd_ptr];

    // Occupancy after this cycle's accepted push/pop
    always_comb begin
        count_next = count + {{(CNT_W-1){1'b0}}, push_ok}
                           - {{(CNT_W-1){1'b0}}, pop_ok};
    end

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-2 depth
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_r <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_next;
            full_r <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Tag storage, data only
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/hue_stage2.sv
// Final RGB-to-hue stage: re-joins the divider quotient with its buffered
// sector/gray tag, scales by 60, adds the sector offset and wraps to 0..359.
// Optional build macro HUE_STAGE2_ROUND_EN: round half up instead of floor.
module hue_stage2
    import hue_pkg::*;
#(
    parameter int DIVIDE_LATENCY = 16,
    parameter int TAG_DEPTH      = 32,
    parameter int QUO_W          = 16,
    parameter int HUE_W          = 9
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_tag_valid,
    input  logic [1:0]              i_sector,
    input  logic                    i_gray,
    input  logic signed [QUO_W-1:0] i_quo,
    input  logic                    i_quo_valid,
    output logic [HUE_W-1:0]        o_hue,
    output logic                    o_valid,
    output logic                    o_tag_full,
    output logic                    o_err
);

    if (TAG_DEPTH < DIVIDE_LATENCY + 2) begin : g_depth_chk
        $error("TAG_DEPTH too small for DIVIDE_LATENCY");
    end
    if ((TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_pow2_chk
        $error("TAG_DEPTH must be a power of 2");
    end
    if (QUO_W < 10) begin : g_quo_chk
        $error("QUO_W must hold +/-256");
    end

    localparam logic signed [QUO_W-1:0] SAT_HI  = QUO_W'(256);
    localparam logic signed [QUO_W-1:0] SAT_LO  = -QUO_W'(256);
    localparam logic signed [16:0]      SCALE_K = 17'(HUE_SCALE);
    localparam logic signed [10:0]      MAX_K   = 11'(HUE_MAX);
`ifdef HUE_STAGE2_ROUND_EN
    localparam logic signed [16:0]      RND_K   = 17'sd128;
`else
    localparam logic signed [16:0]      RND_K   = 17'sd0;
`endif

    // Clamp Q8.8 quotient to +/-1.0
    function automatic logic signed [9:0] sat_quo(input logic signed [QUO_W-1:0] q);
        if (q > SAT_HI)      return 10'sd256;
        else if (q < SAT_LO) return -10'sd256;
        else                 return q[9:0];
    endfunction

    // Saturated quotient times 60, still Q.8
    function automatic logic signed [16:0] scale_quo(input logic signed [QUO_W-1:0] q);
        logic signed [9:0]  s;
        logic signed [16:0] e;
        s = sat_quo(q);
        e = {{7{s[9]}}, s};
        return e * SCALE_K;
    endfunction

    // Drop the fraction: floor, or round half up when enabled
    function automatic logic signed [10:0] round_prod(input logic signed [16:0] p);
        logic signed [16:0] t;
        t = (p + RND_K) >>> 8;
        return t[10:0];
    endfunction

    function automatic logic signed [10:0] sector_offset(input sector_e s);
        case (s)
            SEC_G:   return 11'(HUE_OFF_G);
            SEC_B:   return 11'(HUE_OFF_B);
            default: return 11'(HUE_OFF_R);
        endcase
    endfunction

    // Single-step wrap into 0..359; inputs never leave -360..719
    function automatic logic [HUE_W-1:0] wrap_hue(input logic signed [10:0] h);
        logic signed [10:0] w;
        w = h;
        if (h < 0)           w = h + MAX_K;
        else if (h >= MAX_K) w = h - MAX_K;
        return w[HUE_W-1:0];
    endfunction

    hue_tag_t tag_in;
    hue_tag_t head;
    logic     fifo_empty;
    logic     fifo_ovf;
    logic     fifo_udf;
    logic     take;

    assign tag_in.sector = sector_e'(i_sector);
    assign tag_in.gray   = i_gray;
    assign take          = i_quo_valid & ~fifo_empty;

    hue_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (TAG_W)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_tag_valid),
        .i_data  (tag_in),
        .i_pop   (i_quo_valid),
        .o_head  (head),
        .o_full  (o_tag_full),
        .o_empty (fifo_empty),
        .o_ovf   (fifo_ovf),
        .o_udf   (fifo_udf)
    );

    // ---- stage A: saturate, scale, capture tag ----
    logic               vld_p1;
    logic signed [16:0] prod_p1;
    hue_tag_t           tag_p1;

    // Stage A valid follows a successful pop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) vld_p1 <= 1'b0;
        else       vld_p1 <= take;
    end

    // Stage A data: scaled quotient and its tag
    always_ff @(posedge i_clk) begin
        if (take) begin
            prod_p1 <= scale_quo(i_quo);
            tag_p1  <= head;
        end
    end

    // ---- stage B: shift, offset, wrap, force cases ----
    logic             vld_p2;
    logic [HUE_W-1:0] hue_p2;
    logic [HUE_W-1:0] hue_next;
    logic             err_r;
    logic             rsvd_p1;

    assign rsvd_p1 = (tag_p1.sector == SEC_RSVD);

    // Gray and reserved sectors carry no meaningful hue
    always_comb begin
        hue_next = wrap_hue(sector_offset(tag_p1.sector) + round_prod(prod_p1));
        if (tag_p1.gray || rsvd_p1) hue_next = '0;
    end

    // Output register; hue holds while no result is valid, error is sticky
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p2 <= 1'b0;
            hue_p2 <= '0;
            err_r  <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) hue_p2 <= hue_next;
            err_r  <= err_r | fifo_ovf | fifo_udf | (vld_p1 & rsvd_p1);
        end
    end

    assign o_hue   = hue_p2;
    assign o_valid = vld_p2;
    assign o_err   = err_r;

endmodule
